// File: rtl/mdu_scoreboard_if.sv
// Core-side bundle for the mult/div scoreboard: issue, hazard check,
// completion and regfile writeback signals.
interface mdu_scoreboard_if #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned DATA_W   = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                issue_valid;
    logic [REG_BITS-1:0] issue_rd;
    logic                issue_ready;
    logic [REG_BITS-1:0] chk_a;
    logic [REG_BITS-1:0] chk_b;
    logic                chk_a_used;
    logic                chk_b_used;
    logic [REG_BITS-1:0] chk_d;
    logic                chk_d_used;
    logic                hazard;
    logic                done_valid;
    logic [DATA_W-1:0]   done_data;
    logic                wb_busy;
    logic                wb_en;
    logic [REG_BITS-1:0] wb_reg;
    logic [DATA_W-1:0]   wb_data;
    logic [CNT_W-1:0]    pending;
    logic                err;

    modport master (
        output issue_valid, issue_rd, chk_a, chk_b, chk_a_used, chk_b_used,
               chk_d, chk_d_used, done_valid, done_data, wb_busy,
        input  issue_ready, hazard, wb_en, wb_reg, wb_data, pending, err
    );

    modport slave (
        input  issue_valid, issue_rd, chk_a, chk_b, chk_a_used, chk_b_used,
               chk_d, chk_d_used, done_valid, done_data, wb_busy,
        output issue_ready, hazard, wb_en, wb_reg, wb_data, pending, err
    );
endinterface

// File: rtl/mdu_scoreboard.sv
// In-order scoreboard and writeback buffer for outstanding mult/div results;
// results retire onto the regfile port only in cycles MW leaves it free.
module mdu_scoreboard #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic           clock,
    input  logic           reset,
    mdu_scoreboard_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]    entValid;
    logic [DEPTH-1:0]    entDone;
    logic [REG_BITS-1:0] entRd   [DEPTH];
    logic [DATA_W-1:0]   entData [DEPTH];

    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [PTR_W-1:0] donePtr;
    logic [CNT_W-1:0] count;
    logic             errReg;

    logic issueReady;
    logic issueOk;
    logic issueBad;
    logic doneOk;
    logic doneBad;
    logic headDone;
    logic retire;
    logic hitA;
    logic hitB;
    logic hitD;

    // Completion is in order, so donePtr always names the oldest incomplete
    // entry; when every entry is complete it lands on an invalid or done slot.
    always_comb begin
        issueReady = (count < CNT_W'(DEPTH));
        issueOk    = bus.issue_valid && issueReady;
        issueBad   = bus.issue_valid && !issueReady;
        doneOk     = bus.done_valid && entValid[donePtr] && !entDone[donePtr];
        doneBad    = bus.done_valid && !(entValid[donePtr] && !entDone[donePtr]);
        headDone   = entValid[headPtr] && entDone[headPtr];
        retire     = headDone && !bus.wb_busy;
    end

    always_comb begin
        hitA = 1'b0;
        hitB = 1'b0;
        hitD = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entValid[i]) begin
                if (entRd[i] == bus.chk_a) hitA = 1'b1;
                if (entRd[i] == bus.chk_b) hitB = 1'b1;
                if (entRd[i] == bus.chk_d) hitD = 1'b1;
            end
        end
        // The op launching this cycle is already a hazard source
        if (issueOk) begin
            if (bus.issue_rd == bus.chk_a) hitA = 1'b1;
            if (bus.issue_rd == bus.chk_b) hitB = 1'b1;
            if (bus.issue_rd == bus.chk_d) hitD = 1'b1;
        end
        bus.hazard = (bus.chk_a_used && (bus.chk_a != '0) && hitA)
                  || (bus.chk_b_used && (bus.chk_b != '0) && hitB)
                  || (bus.chk_d_used && (bus.chk_d != '0) && hitD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entRd[i]   <= '0;
                entData[i] <= '0;
            end
            entValid <= '0;
            entDone  <= '0;
            headPtr  <= '0;
            tailPtr  <= '0;
            donePtr  <= '0;
            count    <= '0;
            errReg   <= 1'b0;
        end else begin
            // Issue, completion and retirement always touch distinct slots
            if (issueOk) begin
                entValid[tailPtr] <= 1'b1;
                entDone[tailPtr]  <= 1'b0;
                entRd[tailPtr]    <= bus.issue_rd;
                tailPtr           <= tailPtr + PTR_W'(1);
            end
            if (doneOk) begin
                entDone[donePtr] <= 1'b1;
                entData[donePtr] <= bus.done_data;
                donePtr          <= donePtr + PTR_W'(1);
            end
            if (retire) begin
                entValid[headPtr] <= 1'b0;
                entDone[headPtr]  <= 1'b0;
                entRd[headPtr]    <= '0;
                entData[headPtr]  <= '0;
                headPtr           <= headPtr + PTR_W'(1);
            end
            count <= count + CNT_W'(issueOk) - CNT_W'(retire);
            if (issueBad || doneBad) errReg <= 1'b1;
        end
    end

    always_comb begin
        bus.issue_ready = issueReady;
        bus.wb_en       = retire && (entRd[headPtr] != '0);
        bus.wb_reg      = headDone ? entRd[headPtr] : '0;
        bus.wb_data     = headDone ? entData[headPtr] : '0;
        bus.pending     = count;
        bus.err         = errReg;
    end
endmodule

// File: tb/tb_mdu_scoreboard.sv
// Randomised and directed bench for mdu_scoreboard against a queue-based
// reference model of outstanding mult/div ops.
module tb_mdu_scoreboard;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned REG_BITS = 5;
    localparam int unsigned DATA_W   = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    mdu_scoreboard_if #(.DEPTH(DEPTH), .REG_BITS(REG_BITS), .DATA_W(DATA_W)) bus ();

    mdu_scoreboard #(.DEPTH(DEPTH), .REG_BITS(REG_BITS), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: outstanding ops oldest-first
    int          rdQ[$];
    bit          doneQ[$];
    logic [31:0] dataQ[$];
    bit          modelErr = 1'b0;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit modelReady();
        return rdQ.size() < DEPTH;
    endfunction

    function automatic bit modelHeadDone();
        return (rdQ.size() > 0) && doneQ[0];
    endfunction

    function automatic bit regHit(input int r);
        if (r == 0) return 1'b0;
        foreach (rdQ[i]) if (rdQ[i] == r) return 1'b1;
        if (bus.issue_valid && modelReady() && int'(bus.issue_rd) == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit modelHazard();
        return (bus.chk_a_used && regHit(int'(bus.chk_a)))
            || (bus.chk_b_used && regHit(int'(bus.chk_b)))
            || (bus.chk_d_used && regHit(int'(bus.chk_d)));
    endfunction

    task automatic clearModel();
        rdQ.delete();
        doneQ.delete();
        dataQ.delete();
        modelErr = 1'b0;
    endtask

    task automatic idleInputs();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.chk_a       = '0;
        bus.chk_b       = '0;
        bus.chk_a_used  = 1'b0;
        bus.chk_b_used  = 1'b0;
        bus.chk_d       = '0;
        bus.chk_d_used  = 1'b0;
        bus.done_valid  = 1'b0;
        bus.done_data   = '0;
        bus.wb_busy     = 1'b0;
    endtask

    // Check all outputs mid-cycle, then advance the model across the edge
    task automatic stepCycle();
        bit hd;
        bit ready;
        int idx;
        @(negedge clock);
        hd    = modelHeadDone();
        ready = modelReady();
        checkValue("issue_ready", bus.issue_ready, ready);
        checkValue("pending", bus.pending, rdQ.size());
        checkValue("hazard", bus.hazard, modelHazard());
        checkValue("wb_en", bus.wb_en, hd && !bus.wb_busy && rdQ[0] != 0);
        checkValue("wb_reg", bus.wb_reg, hd ? rdQ[0] : 0);
        checkValue("wb_data", bus.wb_data, hd ? dataQ[0] : 32'h0);
        checkValue("err", bus.err, modelErr);
        if (reset) begin
            clearModel();
        end else begin
            if (bus.done_valid) begin
                idx = -1;
                foreach (doneQ[i]) if (idx < 0 && !doneQ[i]) idx = i;
                if (idx < 0) modelErr = 1'b1;
                else begin
                    doneQ[idx] = 1'b1;
                    dataQ[idx] = bus.done_data;
                end
            end
            if (hd && !bus.wb_busy) begin
                void'(rdQ.pop_front());
                void'(doneQ.pop_front());
                void'(dataQ.pop_front());
            end
            if (bus.issue_valid) begin
                if (ready) begin
                    rdQ.push_back(int'(bus.issue_rd));
                    doneQ.push_back(1'b0);
                    dataQ.push_back(32'h0);
                end else begin
                    modelErr = 1'b1;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic issueOp(input int rd);
        idleInputs();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = REG_BITS'(rd);
        stepCycle();
    endtask

    task automatic doneOp(input logic [31:0] data);
        idleInputs();
        bus.done_valid = 1'b1;
        bus.done_data  = data;
        stepCycle();
    endtask

    initial begin
        idleInputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clearModel();

        // Reset state and single op with 1-cycle writeback latency
        stepCycle();
        issueOp(5);
        idleInputs();
        stepCycle();
        doneOp(32'h0000_0030);
        idleInputs();
        #1;
        checkValue("t1WbEn", bus.wb_en, 1);
        checkValue("t1WbReg", bus.wb_reg, 5);
        checkValue("t1WbData", bus.wb_data, 32'h30);
        checkValue("t1Pending", bus.pending, 1);
        stepCycle();
        checkValue("t1PendingAfter", bus.pending, 0);

        // Hazard window
        idleInputs();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        bus.chk_a       = 5'd3;
        bus.chk_a_used  = 1'b1;
        #1;
        checkValue("t2HazIssue", bus.hazard, 1);
        stepCycle();
        bus.issue_valid = 1'b0;
        #1;
        checkValue("t2HazHeld", bus.hazard, 1);
        bus.chk_a_used = 1'b0;
        #1;
        checkValue("t2HazUnused", bus.hazard, 0);
        bus.chk_a_used = 1'b1;
        bus.chk_a      = 5'd0;
        #1;
        checkValue("t2HazR0", bus.hazard, 0);
        bus.chk_d      = 5'd3;
        bus.chk_d_used = 1'b1;
        #1;
        checkValue("t2HazWaw", bus.hazard, 1);
        bus.chk_d_used = 1'b0;
        bus.chk_a      = 5'd3;
        stepCycle();
        bus.done_valid = 1'b1;
        bus.done_data  = 32'h77;
        stepCycle();
        bus.done_valid = 1'b0;
        #1;
        checkValue("t2HazRetire", bus.hazard, 1);
        stepCycle();
        checkValue("t2HazDropped", bus.hazard, 0);

        // Full buffer, overflow error, in-order writeback
        issueOp(1);
        issueOp(2);
        idleInputs();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        #1;
        checkValue("t3NotReady", bus.issue_ready, 0);
        stepCycle();
        checkValue("t3Err", bus.err, 1);
        checkValue("t3Pending", bus.pending, 2);
        doneOp(32'hA);
        checkValue("t3WbReg1", bus.wb_reg, 1);
        checkValue("t3WbData1", bus.wb_data, 32'hA);
        doneOp(32'hB);
        checkValue("t3WbReg2", bus.wb_reg, 2);
        checkValue("t3WbData2", bus.wb_data, 32'hB);
        idleInputs();
        stepCycle();

        // Deferred retirement under wb_busy
        issueOp(7);
        doneOp(32'h55);
        for (int i = 0; i < 3; i++) begin
            idleInputs();
            bus.wb_busy = 1'b1;
            #1;
            checkValue("t4Deferred", bus.wb_en, 0);
            stepCycle();
        end
        idleInputs();
        #1;
        checkValue("t4WbEn", bus.wb_en, 1);
        checkValue("t4WbData", bus.wb_data, 32'h55);
        stepCycle();

        // Issue + done + retire together at pending=1
        issueOp(4);
        doneOp(32'h44);
        idleInputs();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd6;
        bus.done_valid  = 1'b1;
        bus.done_data   = 32'h66;
        stepCycle();
        checkValue("t5Pending", bus.pending, 1);
        doneOp(32'h66);
        idleInputs();
        stepCycle();

        // Pointer wrap
        for (int i = 0; i < 3 * DEPTH; i++) begin
            issueOp(10 + i);
            doneOp(32'h100 + i);
        end
        idleInputs();
        stepCycle();

        // Stray done and reset mid-operation
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        doneOp(32'hDEAD);
        checkValue("t6StrayErr", bus.err, 1);
        checkValue("t6StrayWb", bus.wb_en, 0);
        issueOp(8);
        issueOp(9);
        idleInputs();
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkValue("t6RstPending", bus.pending, 0);
        checkValue("t6RstErr", bus.err, 0);
        for (int i = 0; i < 3; i++) begin
            idleInputs();
            #1;
            checkValue("t6RstNoWb", bus.wb_en, 0);
            stepCycle();
        end

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            bus.issue_valid = ($urandom_range(0, 99) < 45);
            bus.issue_rd    = REG_BITS'($urandom_range(0, 7));
            bus.chk_a       = REG_BITS'($urandom_range(0, 7));
            bus.chk_b       = REG_BITS'($urandom_range(0, 7));
            bus.chk_d       = REG_BITS'($urandom_range(0, 7));
            bus.chk_a_used  = $urandom_range(0, 1) == 1;
            bus.chk_b_used  = $urandom_range(0, 1) == 1;
            bus.chk_d_used  = $urandom_range(0, 1) == 1;
            bus.done_valid  = ($urandom_range(0, 99) < 40);
            bus.done_data   = $urandom;
            bus.wb_busy     = ($urandom_range(0, 99) < 30);
            reset           = ($urandom_range(0, 199) == 0);
            stepCycle();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/mdu_scoreboard.md
# mdu_scoreboard

Parametrised in-order scoreboard and writeback buffer for long-latency multiply/divide operations. It sits beside the execute stage of the 5-stage pipeline. Its job is to track up to DEPTH outstanding mult/div destinations so the core can keep issuing independent instructions, rather than stalling the whole pipe for every mult/div. It raises a hazard for dependent instructions, buffers completed results, and inserts them onto the register-file write port only in cycles the MW stage does not use.

## Interface
- DEPTH, 2, max outstanding mult/div ops; power of two, >= 2
- REG_BITS, 5, register index width
- DATA_W, 32, result width
- clock  in  1  master clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- issue_valid  in  1  DX-stage mult/div launching this cycle
- issue_rd  in  REG_BITS  destination of launching op
- issue_ready  out  1  slot available (count < DEPTH)
- chk_a, chk_b  in  REG_BITS  source registers of instruction under hazard check
- chk_a_used, chk_b_used  in  1  source actually read
- chk_d  in  REG_BITS  destination of instruction under check
- chk_d_used  in  1  instruction writes chk_d
- hazard  out  1  instruction under check must stall
- done_valid  in  1  multdiv unit result ready (one-cycle pulse)
- done_data  in  DATA_W  result accompanying done_valid
- wb_busy  in  1  MW stage owns the regfile write port this cycle
- wb_en  out  1  scoreboard writes regfile this cycle
- wb_reg  out  REG_BITS  write register
- wb_data  out  DATA_W  write data
- pending  out  clog2(DEPTH+1)  occupied entry count
- err  out  1  sticky protocol error

## Operation
- Circular buffer of DEPTH entries: {valid, complete, rd, data}; head (oldest), tail, count; pointers wrap modulo DEPTH.
- Issue: issue_valid && issue_ready writes {1,0,issue_rd,x} at tail; tail++, count++.
- Completion is in order. done_valid marks the oldest valid && !complete entry complete and stores done_data. If no such entry exists, the pulse is ignored and err is set.
- Issue when !issue_ready: ignored, err set.
- Retire: head complete && !wb_busy drives wb_en=1, wb_reg=rd, wb_data=data. At the edge, head is cleared, head++, count--.
  - If rd==0, the entry retires the same way but wb_en stays 0.
- Hazard (combinational):
  - chk_a_used && chk_a!=0 matches rd of any valid entry, OR matches issue_rd while issue_valid && issue_ready; or
  - the same rule applied to chk_b; or
  - chk_d_used && chk_d!=0 matches a valid entry rd (WAW: prevents ALU write being overwritten later).
  - Issue-cycle bypass also applies to chk_d.
- Entries remain hazard sources until retired. Completed-but-unretired results are not forwarded.
- Simultaneous events are all legal in one cycle: issue + done + retire.
  - count updates by +issue −retire.
  - issue_ready uses registered count only; no same-cycle slot reuse when full.
  - done never targets the entry being written by the same-cycle issue.
- err is cleared only by reset.

## Timing
- Reset values: pending=0, issue_ready=1, hazard=0 (given zero check inputs), wb_en=0, wb_reg=0, wb_data=0, err=0; all entries invalid.
- Reset beats every simultaneous issue/done in that cycle. Reset mid-operation discards all entries with no writeback.
- issue_ready, wb_en, wb_reg, wb_data derive from registered state (plus wb_busy for wb_en). hazard is combinational from state and inputs.
- Minimum latency is 1 cycle: done_valid at edge N drives wb_en high during cycle N+1 if wb_busy=0.
- wb_busy=1 defers retirement indefinitely with no loss. Outputs hold while deferred.
- The hazard from an issued rd persists from the issue cycle through the retire cycle inclusive, and drops the cycle after.

## Test plan
- Reset, then issue rd=5, done_data=0x0000_0030 two cycles later, wb_busy=0 → wb_en=1, wb_reg=5, wb_data=0x30 one cycle after done; pending 1→0.
- Issue rd=3, then chk_a=3 used → hazard=1 in the issue cycle and until retire. chk_a=0 or chk_a_used=0 → hazard=0. chk_d=3 used → hazard=1.
- DEPTH=2: issue rd=1, rd=2, third issue → issue_ready=0, err=1, pending=2. Dones in order with data 0xA, 0xB → writebacks r1=0xA then r2=0xB.
- Result complete while wb_busy=1 for 3 cycles → wb_en=0 for those cycles; writes in the first cycle wb_busy=0.
- Issue + done + retire in the same cycle at pending=1 → pending stays 1. Pointer wrap over 3×DEPTH ops → all results correct, in order.
- done_valid with pending=0 → err=1, no writeback. Reset with 2 pending → pending=0, no wb_en afterward, err=0.
